// File: rtl/latency_ram_pkg.sv
// Shared constants, control state type and byte-lane merge helper for latency_ram.
// Purely declarative: no latency and no flow control of its own.
package latency_ram_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DEPTH     = 64;
  localparam int DEF_LATENCY   = 2;
  localparam int DEF_PIPELINED = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ctrl_state_e;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/latency_ram_delay_line.sv
// Fixed LATENCY-stage shift line carrying response valid/data/err.
// No backpressure: every entry falls out of the last stage exactly LATENCY edges after entry.
module ram_delay_line
  import latency_ram_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  logic [LATENCY-1:0]             vld_q;
  logic [LATENCY-1:0][DATA_W-1:0] dat_q;
  logic [LATENCY-1:0]             err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      dat_q <= '0;
      err_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      dat_q[0] <= in_data;
      err_q[0] <= in_err;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
        err_q[i] <= err_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];

endmodule

// File: rtl/latency_ram.sv
// Word-addressed RAM with byte enables and a fixed request-to-response latency (1..4).
// Responses cannot be stalled; PIPELINED=0 holds req_ready low while a request is in flight.
module latency_ram
  import latency_ram_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int PIPELINED = DEF_PIPELINED
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   r_data,
  output logic                resp_err
);

  localparam int BE_W   = DATA_W / 8;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [ADDR_W-3:0] word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] resp_dat;
  logic              resp_err_in;
  logic              unused_addr_lsb;

  logic              ready_en_q;
  ctrl_state_e       state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;

  assign word_idx        = addr[ADDR_W-1:2];
  assign unused_addr_lsb = ^addr[1:0];
  assign in_range        = (64'(word_idx) < 64'(DEPTH));
  assign mem_idx         = word_idx[MEM_AW-1:0];
  assign rd_word         = mem[mem_idx];

  assign accept    = req_valid && req_ready;
  assign req_ready = ready_en_q && ((PIPELINED != 0) || (state_q == ST_IDLE));

  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < BE_W; b++) begin
      wr_word[b*8 +: 8] = merge_byte(rd_word[b*8 +: 8], w_data[b*8 +: 8], byte_en[b]);
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && wr_en && in_range) begin
      mem[mem_idx] <= wr_word;
    end
  end

  // Only an accepted in-range read carries data; everything else enters the line as zero.
  assign resp_dat    = (accept && !wr_en && in_range) ? rd_word : '0;
  assign resp_err_in = accept && !in_range;

  ram_delay_line #(
    .LATENCY (LATENCY),
    .DATA_W  (DATA_W)
  ) u_delay_line (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_data   (resp_dat),
    .in_err    (resp_err_in),
    .out_valid (resp_valid),
    .out_data  (r_data),
    .out_err   (resp_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en_q <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
    end else begin
      ready_en_q <= 1'b1;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  // BUSY counts edges so it leaves on the same edge that raises resp_valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (LATENCY > 1)) begin
          state_d = ST_BUSY;
          cnt_d   = 2'd0;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 2'(LATENCY - 2)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/latency_ram.md
LATENCY_RAM -- requirements
Module: latency_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-003 SHALL have parameter DEPTH, default 64: number of words of storage.
REQ-004 SHALL have parameter LATENCY, default 2: cycles from request accept to response, legal range 1..4.
REQ-005 SHALL have parameter PIPELINED, default 1: 1 allows one new request per cycle; 0 allows one outstanding request.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port req_valid, input, 1: request present.
REQ-009 SHALL have port req_ready, output, 1: request can be accepted this cycle.
REQ-010 SHALL have port wr_en, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have port addr, input, ADDR_W: byte address; word index is addr[ADDR_W-1:2].
REQ-012 SHALL have port w_data, input, DATA_W: write data.
REQ-013 SHALL have port byte_en, input, DATA_W/8: per-byte write enable.
REQ-014 SHALL have port resp_valid, output, 1: one-cycle response pulse.
REQ-015 SHALL have port r_data, output, DATA_W: read data, qualified by resp_valid.
REQ-016 SHALL have port resp_err, output, 1: out-of-range access flag, qualified by resp_valid.

Function
REQ-017 A request SHALL be accepted in a cycle where req_valid and req_ready are both 1 at the rising edge.
REQ-018 Every accepted request, read or write, SHALL produce exactly one resp_valid pulse exactly LATENCY cycles after the accept edge.
- Responses SHALL be delivered in accept order.
- No response backpressure.
REQ-019 A write SHALL commit to storage at the accept edge.
- Only bytes whose byte_en bit is 1 are updated.
- The write response SHALL carry r_data = 0.
REQ-020 A read SHALL sample storage at the accept edge.
- A read accepted one or more cycles after a write to the same word SHALL return the written data.
REQ-021 When word index >= DEPTH, the access SHALL be out of range:
- a write is discarded;
- a read returns r_data = 0;
- the response carries resp_err = 1.
REQ-022 When PIPELINED=1, req_ready SHALL be 1 whenever reset is deasserted.
REQ-023 When PIPELINED=0, the control state machine SHALL behave as follows:
- States: IDLE (req_ready=1) and BUSY (req_ready=0).
- IDLE->BUSY on accept.
- BUSY->IDLE on the edge that raises resp_valid, so req_ready is 1 in the response cycle.
REQ-024 Response timing SHALL use a LATENCY-stage valid/data/err shift line.
- PIPELINED=1 with a continuous req_valid SHALL yield resp_valid high every cycle after the initial LATENCY-cycle fill.
REQ-025 When resp_valid is 0, r_data and resp_err SHALL be 0.

Reset
REQ-026 Asserting reset low SHALL immediately force:
- resp_valid = 0, r_data = 0, resp_err = 0;
- all in-flight stages cleared, and those responses never delivered;
- state = IDLE, req_ready = 0.
REQ-027 req_ready SHALL go to 1 at the first rising clk edge after reset deasserts.
REQ-028 Storage contents SHALL NOT be cleared by reset.
- A write accepted before reset remains readable after it.

Structure
REQ-029 A shared package latency_ram_pkg SHALL hold:
- default parameter constants;
- the IDLE/BUSY state type;
- the byte-lane merge function.
REQ-030 The delay line SHALL be a sub-module ram_delay_line, parametrised by LATENCY and DATA_W, carrying valid, data and err.

Verification
REQ-031 Write then read: LATENCY=2, write addr=84, w_data=7, byte_en=4'hF; next cycle read addr=84 -> read response 2 cycles after its accept with r_data=7, resp_err=0; write response r_data=0.
REQ-032 Byte enable: word 0 holds 32'h11223344; write 32'hAABBCCDD with byte_en=4'b0101 -> read of word 0 returns 32'h11BB33DD.
REQ-033 Back-to-back: PIPELINED=1, LATENCY=3, reads of addr 0,4,8,12 on four consecutive cycles -> four consecutive resp_valid pulses starting 3 cycles after the first accept, data in order.
REQ-034 Single outstanding: PIPELINED=0, LATENCY=4, req_valid held high -> accepts every 4 cycles; req_ready=0 for 3 cycles after each accept.
REQ-035 Out of range: DEPTH=64, write then read addr=256 -> both responses resp_err=1, read r_data=0; word 0 unchanged.
REQ-036 Reset mid-operation: reset low one cycle after a read accept -> no resp_valid pulse ever for that read; data written before reset still reads back afterward.
